// File: rtl/led_pkg.sv
// led_pkg: shared PWM width and fade FSM state encoding.
package led_pkg;
    localparam int PWM_BITS = 8;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_e;
endpackage

// File: rtl/fade_tick_gen.sv
// fade_tick_gen: 256-clock PWM period counter and fade step divider.
module fade_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic step_clr,
    output logic period_start,
    output logic boundary,
    output logic step_tick
);
    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [15:0] step_q, step_d;
    assign boundary     = cnt_q == '1;
    assign period_start = cnt_q == '0 && !reset;
    assign step_tick    = boundary && step_q == STEP_LAST;
    always_comb begin
        cnt_d  = cnt_q + PWM_BITS'(1);
        step_d = !boundary ? step_q : (step_clr || step_q == STEP_LAST) ? '0 : step_q + 16'd1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            step_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end
endmodule

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: fades a PWM duty level between min_level and max_level with hold phases.
module led_fade_sequencer
    import led_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 4,
    parameter int unsigned HOLD_STEPS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] min_level,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [PWM_BITS-1:0] level,
    output logic                period_start,
    output logic [2:0]          phase,
    output logic                cycle_done
);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_STEPS - 1);
    state_e state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [15:0] hold_q, hold_d;
    logic cycle_done_q, cycle_done_d;
    logic boundary, step_tick, step_clr, degen;
    logic [PWM_BITS:0] up, dn;

    fade_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk         (clk),
        .reset       (reset),
        .step_clr    (step_clr),
        .period_start(period_start),
        .boundary    (boundary),
        .step_tick   (step_tick)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        hold_d       = hold_q;
        cycle_done_d = 1'b0;
        step_clr     = 1'b0;
        up           = {1'b0, level_q} + (PWM_BITS+1)'(1);
        dn           = {1'b0, level_q} - (PWM_BITS+1)'(1);
        // an empty or inverted range pins the level at min and lets every exit fire on its first tick
        degen        = max_level <= min_level;
        if (boundary) begin
            if (!enable || state_q == IDLE) begin
                state_d  = enable ? RAMP_UP : IDLE;
                level_d  = min_level;
                hold_d   = '0;
                step_clr = 1'b1;
            end else if (step_tick) begin
                case (state_q)
                    RAMP_UP: begin
                        level_d = degen ? min_level : up >= {1'b0, max_level} ? max_level : up[PWM_BITS-1:0];
                        state_d = (degen || up >= {1'b0, max_level}) ? HOLD_HI : RAMP_UP;
                    end
                    RAMP_DOWN: begin
                        level_d = (degen || $signed(dn) <= $signed({1'b0, min_level})) ? min_level : dn[PWM_BITS-1:0];
                        state_d = (degen || $signed(dn) <= $signed({1'b0, min_level})) ? HOLD_LO : RAMP_DOWN;
                    end
                    HOLD_HI, HOLD_LO: begin
                        if (degen || hold_q == HOLD_LAST) begin
                            hold_d       = '0;
                            state_d      = state_q == HOLD_HI ? RAMP_DOWN : RAMP_UP;
                            cycle_done_d = state_q == HOLD_LO;
                        end else begin
                            hold_d = hold_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            level_q      <= '0;
            hold_q       <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign level      = level_q;
    assign phase      = state_q;
    assign cycle_done = cycle_done_q;
endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb_led_fade_sequencer: two parameterisations checked every clock against a period-level model.
module tb_led_fade_sequencer;
    logic clk = 1'b0;
    logic reset, enable;
    logic [7:0] min_level, max_level;
    logic [7:0] lvl [2];
    logic [2:0] ph [2];
    logic ps [2];
    logic cd [2];

    int checks = 0, passes = 0, fails = 0;
    int m_cnt = 0;
    int m_st [2], m_lvl [2], m_stp [2], m_hld [2], m_cd [2];
    bit m_rst;
    int div_k [2] = '{1, 3};
    int hold_k [2] = '{2, 3};
    int cd_cnt = 0;
    int cyc = 0, last_ps = -1;
    logic [7:0] prev_lvl = 0;

    int exp_seq [14] = '{0, 1, 2, 3, 4, 4, 4, 3, 2, 1, 0, 0, 0, 1};
    int exp_sat [16] = '{250, 251, 252, 253, 254, 255, 255, 255, 254, 253, 252, 251, 250, 250, 250, 251};
    int exp_deg [6]  = '{1, 2, 3, 4, 1, 2};

    always #5 clk = ~clk;

    led_fade_sequencer #(.STEP_DIV(1), .HOLD_STEPS(2)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .min_level(min_level), .max_level(max_level),
        .level(lvl[0]), .period_start(ps[0]), .phase(ph[0]), .cycle_done(cd[0]));
    led_fade_sequencer #(.STEP_DIV(3), .HOLD_STEPS(3)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .min_level(min_level), .max_level(max_level),
        .level(lvl[1]), .period_start(ps[1]), .phase(ph[1]), .cycle_done(cd[1]));

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else begin
            fails++;
            if (fails <= 30) $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // one period boundary of the fade, from the behavioural rules
    task automatic boundary_model(input int k);
        int mn, mx, nxt;
        bit degen;
        mn = min_level;
        mx = max_level;
        degen = mx <= mn;
        if (!enable || m_st[k] == 0) begin
            m_st[k] = enable ? 1 : 0;
            m_lvl[k] = mn;
            m_stp[k] = 0;
            m_hld[k] = 0;
            return;
        end
        m_stp[k] = (m_stp[k] + 1) % div_k[k];
        if (m_stp[k] != 0) return;
        if (m_st[k] == 1) begin
            nxt = m_lvl[k] + 1;
            if (degen) begin m_lvl[k] = mn; m_st[k] = 2; end
            else if (nxt >= mx) begin m_lvl[k] = mx; m_st[k] = 2; end
            else m_lvl[k] = nxt;
        end else if (m_st[k] == 3) begin
            nxt = m_lvl[k] - 1;
            if (degen || nxt <= mn) begin m_lvl[k] = mn; m_st[k] = 4; end
            else m_lvl[k] = nxt;
        end else begin
            m_hld[k]++;
            if (degen || m_hld[k] >= hold_k[k]) begin
                m_hld[k] = 0;
                m_cd[k] = m_st[k] == 4;
                m_st[k] = m_st[k] == 2 ? 3 : 1;
            end
        end
    endtask

    always @(posedge clk) begin
        m_rst = reset;
        if (reset) begin
            m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_st[k] = 0; m_lvl[k] = 0; m_stp[k] = 0; m_hld[k] = 0; m_cd[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_cd[k] = 0;
                if (m_cnt == 255) boundary_model(k);
            end
            m_cnt = (m_cnt + 1) % 256;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            chk("level", k, lvl[k], m_lvl[k]);
            chk("phase", k, ph[k], m_st[k]);
            chk("cycle_done", k, cd[k], m_cd[k]);
            chk("period_start", k, ps[k], (m_cnt == 0 && !reset) ? 1 : 0);
        end
        if (cd[0]) cd_cnt++;
        if (!m_rst && lvl[0] != prev_lvl) chk("level_change_on_ps", 0, ps[0], 1);
        if (m_rst) last_ps = -1;
        else if (ps[0]) begin
            if (last_ps >= 0) chk("ps_interval", 0, cyc - last_ps, 256);
            last_ps = cyc;
        end
        prev_lvl = lvl[0];
    end

    task automatic to_ps();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (m_cnt != 0 && n < 300);
        chk("ps_align", 0, ps[0], 1);
    endtask

    task automatic restart(input int mn, input int mx);
        enable = 1'b0;
        min_level = 8'(mn);
        max_level = 8'(mx);
        to_ps();
        enable = 1'b1;
        to_ps();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; min_level = 8'd0; max_level = 8'd4;
        repeat (3) @(negedge clk);
        chk("rst_level", 0, lvl[0], 0);
        chk("rst_phase", 0, ph[0], 0);
        chk("rst_period_start", 0, ps[0], 0);
        chk("rst_cycle_done", 0, cd[0], 0);
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 26; i++) begin
            to_ps();
            if (i == 0) cd_cnt = 0;
            if (i < 14) chk("seq_level", i, lvl[0], exp_seq[i]);
        end
        chk("seq_cycle_done_count", 0, cd_cnt, 2);

        restart(250, 255);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) to_ps();
            chk("sat_level", i, lvl[0], exp_sat[i]);
        end

        restart(100, 50);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) to_ps();
            chk("degen_phase", i, ph[0], exp_deg[i]);
            chk("degen_level", i, lvl[0], 100);
        end

        restart(10, 200);
        repeat (27) to_ps();
        chk("dis_level_before", 0, lvl[0], 37);
        chk("dis_phase_before", 0, ph[0], 1);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_level_mid_period", 0, lvl[0], 37);
        to_ps();
        chk("dis_level", 0, lvl[0], 10);
        chk("dis_phase", 0, ph[0], 0);
        enable = 1'b1;
        to_ps();
        chk("reen_level", 0, lvl[0], 10);
        chk("reen_phase", 0, ph[0], 1);
        to_ps();
        chk("reen_level_next", 0, lvl[0], 11);

        restart(190, 220);
        repeat (10) to_ps();
        chk("pre_reset_level", 0, lvl[0], 200);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_level", 0, lvl[0], 0);
        chk("mid_reset_phase", 0, ph[0], 0);
        chk("mid_reset_period_start", 0, ps[0], 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_period_start", 0, ps[0], 1);

        for (int i = 0; i < 150; i++) begin
            int r;
            repeat ($urandom_range(50, 400)) @(negedge clk);
            r = $urandom % 16;
            if (r == 0) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
            end else if (r < 3) begin
                enable = ($urandom % 4) != 0;
            end else if (r < 9) begin
                min_level = 8'($urandom_range(0, 255));
                max_level = (r < 7) ? 8'($urandom_range(0, 255)) : 8'(min_level + 8'($urandom_range(0, 6)));
                enable = 1'b1;
            end
        end
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
